// File: rtl/syscall_unit.sv
// syscall_unit: console syscall services (print int, print string, print char, exit)
// driven from the writeback stage; characters leave through a valid/ready port.
module syscall_unit #(
    parameter int MAX_STR_LEN = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        busy,
    output logic        halt,
    output logic        err,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata
);
    typedef enum logic [2:0] {IDLE, INT_CONV, EMIT, STR_REQ, STR_WAIT, HALT} state_t;

    localparam logic [31:0] POW [10] = '{32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000,
        32'd100000, 32'd1000000, 32'd10000000, 32'd100000000, 32'd1000000000};

    state_t      state, state_d, ret;
    logic [31:0] a0_r, val, idx;
    logic [3:0]  pidx, digit;
    logic        neg, started, emit_int, known;

    assign char_valid = state == EMIT;
    assign mem_rd     = state == STR_REQ;
    assign mem_addr   = a0_r + idx;
    assign known      = v0 == 32'd1 || v0 == 32'd4 || v0 == 32'd10 || v0 == 32'd11;

    always_comb begin
        emit_int = !neg && val < POW[pidx] && (digit != 4'd0 || started || pidx == 4'd0);
        state_d  = state;
        case (state)
            IDLE:     if (syscall) state_d = v0 == 32'd1 ? INT_CONV : v0 == 32'd4 ? STR_REQ :
                                             v0 == 32'd10 ? HALT : v0 == 32'd11 ? EMIT : IDLE;
            INT_CONV: state_d = (neg || emit_int) ? EMIT : INT_CONV;
            EMIT:     state_d = char_ready ? ret : EMIT;
            STR_REQ:  state_d = STR_WAIT;
            STR_WAIT: state_d = mem_rdata == 8'd0 ? IDLE : EMIT;
            default:  state_d = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ret       <= IDLE;
            a0_r      <= '0;
            val       <= '0;
            idx       <= '0;
            pidx      <= '0;
            digit     <= '0;
            neg       <= 1'b0;
            started   <= 1'b0;
            char_data <= '0;
            busy      <= 1'b0;
            halt      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= state_d != IDLE;
            halt  <= state_d == HALT;
            err   <= state == IDLE && syscall && !known;
            case (state)
                IDLE: if (syscall) begin
                    a0_r      <= a0;
                    idx       <= '0;
                    val       <= a0[31] ? 32'd0 - a0 : a0;
                    neg       <= a0[31];
                    pidx      <= 4'd9;
                    digit     <= '0;
                    started   <= 1'b0;
                    char_data <= a0[7:0];
                    ret       <= IDLE;
                end
                // One subtraction per cycle; a digit is final once the remainder drops below the power.
                INT_CONV: if (neg) begin
                    neg       <= 1'b0;
                    char_data <= 8'h2D;
                    ret       <= INT_CONV;
                end else if (val >= POW[pidx]) begin
                    val   <= val - POW[pidx];
                    digit <= digit + 4'd1;
                end else begin
                    if (emit_int) begin
                        char_data <= 8'h30 + {4'd0, digit};
                        started   <= 1'b1;
                        ret       <= pidx == 4'd0 ? IDLE : INT_CONV;
                    end
                    pidx  <= pidx - 4'd1;
                    digit <= '0;
                end
                STR_WAIT: if (mem_rdata != 8'd0) begin
                    char_data <= mem_rdata;
                    idx       <= idx + 32'd1;
                    ret       <= idx + 32'd1 == 32'(MAX_STR_LEN) ? IDLE : STR_REQ;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: randomized directed checks of syscall_unit against a
// reference built from printf formatting and a byte-memory model.
module tb_syscall_unit;
    localparam int MAXL = 256;

    logic        clk = 1'b0, reset, syscall, char_ready;
    logic [31:0] v0, a0, mem_addr;
    logic        busy, halt, err, char_valid, mem_rd;
    logic [7:0]  char_data, mem_rdata;

    int          total = 0, bad = 0;
    logic [7:0]  mem_map [logic [31:0]];
    logic [7:0]  got[$], expq[$];
    logic [31:0] addrs[$];
    logic        rd_q = 1'b0;
    logic [7:0]  rbyte = 8'h00;

    always #5 clk = ~clk;

    syscall_unit #(.MAX_STR_LEN(MAXL)) dut (
        .clk(clk), .reset(reset), .syscall(syscall), .v0(v0), .a0(a0),
        .busy(busy), .halt(halt), .err(err), .char_valid(char_valid),
        .char_data(char_data), .char_ready(char_ready), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] mem_byte(logic [31:0] a);
        return mem_map.exists(a) ? mem_map[a] : ((a[7:0] ^ 8'h5A) | 8'h01);
    endfunction

    // Memory answers exactly one cycle after the request; garbage otherwise.
    always @(posedge clk) begin
        rd_q  <= mem_rd;
        rbyte <= mem_byte(mem_addr);
    end
    assign mem_rdata = rd_q ? rbyte : 8'hEE;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_int(logic [31:0] a);
        string s = $sformatf("%0d", $signed(a));
        expq.delete();
        for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
    endfunction

    function automatic void exp_str(logic [31:0] a);
        expq.delete();
        for (int i = 0; i < MAXL; i++) begin
            if (mem_byte(a + 32'(i)) == 8'd0) break;
            expq.push_back(mem_byte(a + 32'(i)));
        end
    endfunction

    task automatic cmp(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'(expq.size()));
        foreach (expq[i]) if (i < got.size()) chk(tag, got[i], expq[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_halt"}, halt, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_valid"}, char_valid, 0);
        chk({tag, "_data"}, char_data, 0);
        chk({tag, "_rd"}, mem_rd, 0);
        chk({tag, "_addr"}, mem_addr, 0);
    endtask

    // Issue one syscall and run it to completion. pct<0 holds ready low for
    // the first three cycles a character is presented.
    task automatic run_call(input logic [31:0] code, input logic [31:0] arg, input int pct,
                            input bit tail);
        bit         prev_x = 0, prev_hold = 0, done = 0;
        logic [7:0] prev_d = 0;
        int         lowcnt = 0;
        got.delete();
        addrs.delete();
        syscall = 1'b1; v0 = code; a0 = arg;
        @(posedge clk); #1;
        syscall = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            if (pct < 0) begin
                char_ready = !(char_valid && lowcnt < 3);
                if (char_valid && !char_ready) lowcnt++;
            end else char_ready = ($urandom_range(99) < pct);
            syscall = ($urandom_range(3) == 0); v0 = 32'd11; a0 = $urandom;
            @(negedge clk);
            chk("rd_with_valid", mem_rd & char_valid, 0);
            if (prev_hold) begin
                chk("hold_valid", char_valid, 1);
                chk("hold_data", char_data, prev_d);
            end
            if (!busy) begin
                done = 1;
                syscall = 1'b0;
                if (tail) chk("busy_after_last", prev_x, 1);
            end else begin
                if (mem_rd) addrs.push_back(mem_addr);
                prev_x = char_valid && char_ready;
                prev_hold = char_valid && !char_ready;
                prev_d = char_data;
                if (prev_x) got.push_back(char_data);
            end
            @(posedge clk); #1;
        end
        chk("call_finished", done, 1);
        syscall = 1'b0;
        char_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] base, r;
        reset = 1'b1; syscall = 1'b0; char_ready = 1'b0; v0 = '0; a0 = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        exp_int(32'd0);
        run_call(32'd1, 32'd0, 100, 1);
        cmp("int_zero");

        exp_int(32'hFFFFFF85);
        run_call(32'd1, 32'hFFFFFF85, 50, 1);
        cmp("int_neg123");

        exp_int(32'h80000000);
        run_call(32'd1, 32'h80000000, 60, 1);
        cmp("int_min");

        exp_int(32'h7FFFFFFF);
        run_call(32'd1, 32'h7FFFFFFF, 80, 1);
        cmp("int_max");

        mem_map.delete();
        mem_map[32'h100] = 8'h48; mem_map[32'h101] = 8'h69; mem_map[32'h102] = 8'h00;
        exp_str(32'h100);
        run_call(32'd4, 32'h100, -1, 0);
        cmp("str_hi");
        chk("hi_addr_count", 64'(addrs.size()), 3);
        for (int i = 0; i < 3 && i < addrs.size(); i++) chk("hi_addr", addrs[i], 32'h100 + 32'(i));

        mem_map.delete();
        exp_str(32'hFFFFFFFF);
        run_call(32'd4, 32'hFFFFFFFF, 70, 1);
        cmp("str_wrap");
        chk("wrap_len", 64'(got.size()), MAXL);
        if (addrs.size() > 1) chk("wrap_addr1", addrs[1], 32'h0);
        else chk("wrap_addr_count", 64'(addrs.size()), MAXL);

        exp_int({24'd0, 8'h41});
        expq.delete(); expq.push_back(8'h41);
        run_call(32'd11, 32'hDEAD_BE41, 40, 1);
        cmp("putc");

        for (int t = 0; t < 8; t++) begin
            r = $urandom;
            case ($urandom_range(2))
                0: begin
                    exp_int(r);
                    run_call(32'd1, r, $urandom_range(30, 100), 1);
                    cmp("rand_int");
                end
                1: begin
                    mem_map.delete();
                    n = $urandom_range(0, 20);
                    for (int i = 0; i < n; i++) mem_map[r + 32'(i)] = 8'($urandom_range(1, 255));
                    mem_map[r + 32'(n)] = 8'h00;
                    exp_str(r);
                    run_call(32'd4, r, $urandom_range(30, 100), 0);
                    cmp("rand_str");
                end
                default: begin
                    expq.delete(); expq.push_back(r[7:0]);
                    run_call(32'd11, r, $urandom_range(30, 100), 1);
                    cmp("rand_putc");
                end
            endcase
        end

        syscall = 1'b1; v0 = 32'd5; a0 = $urandom; char_ready = 1'b1;
        @(posedge clk); #1;
        syscall = 1'b0;
        @(negedge clk);
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_valid", char_valid, 0);
        @(negedge clk);
        chk("err_drop", err, 0);
        chk("err_still_idle", busy, 0);
        @(posedge clk); #1;
        char_ready = 1'b0;

        mem_map.delete();
        base = 32'h2000;
        for (int i = 0; i < 10; i++) mem_map[base + 32'(i)] = 8'h61 + 8'(i);
        mem_map[base + 32'd10] = 8'h00;
        syscall = 1'b1; v0 = 32'd4; a0 = base;
        @(posedge clk); #1;
        syscall = 1'b0; char_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 50 && n == 0; c++) begin
            @(negedge clk);
            if (char_valid && char_ready) n++;
            @(posedge clk); #1;
        end
        chk("pre_reset_xfer", n, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (char_valid || mem_rd || busy) n++;
            @(posedge clk); #1;
        end
        chk("post_reset_activity", n, 0);
        char_ready = 1'b0;

        syscall = 1'b1; v0 = 32'd10; a0 = $urandom;
        @(posedge clk); #1;
        syscall = 1'b0;
        @(negedge clk);
        chk("halt_set", halt, 1);
        chk("halt_busy", busy, 1);
        @(posedge clk); #1;
        syscall = 1'b1; v0 = 32'd11; a0 = 32'h41; char_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (char_valid || mem_rd || !halt || !busy) n++;
            @(posedge clk); #1;
        end
        chk("halt_ignores", n, 0);
        syscall = 1'b0; char_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("halt_cleared", halt, 0);
        chk("halt_busy_cleared", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        exp_int(32'd42);
        run_call(32'd1, 32'd42, 100, 1);
        cmp("after_halt_int");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
